packet_receive_buffer: RTL and testbench

Receive-side counterpart of the packet transfer path: accepts a flit stream over a valid/ready handshake, reassembles the flits into a complete packet, and presents that packet to the packet controller as one wide word. The consumer frees the packet with a one-cycle consume pulse. It sits between the router's local ejection port and the packet controller's receive slot table. It holds one packet under assembly plus one completed packet, so a new packet can arrive while the previous one waits to be consumed.

---
 rtl/packet_receive_buffer.sv | 147 ++++++++++++++
 tb/tb_packet_receive_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_receive_buffer.sv
// Receive-side packet reassembly: collects a flit stream into one assembly buffer
// and hands completed packets to a single-entry output register for the consumer.
module packet_receive_buffer #(
  parameter int FLIT_WIDTH = 64,
  parameter int MAX_FLITS  = 8,
  parameter int CNT_W      = $clog2(MAX_FLITS + 1)
) (
  input  logic                            nocclk,
  input  logic                            rst_n,
  input  logic                            received_flit_valid,
  input  logic [FLIT_WIDTH-1:0]           received_flit,
  output logic                            received_flit_ready,
  output logic                            received_packet_valid,
  output logic [MAX_FLITS*FLIT_WIDTH-1:0] received_packet_flit,
  output logic [CNT_W-1:0]                received_packet_tail_index,
  input  logic                            received_packet_consumed,
  output logic                            protocol_error
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSEMBLE = 2'd1,
    S_DISCARD  = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_t;

  localparam logic [1:0] T_HEAD      = 2'b00;
  localparam logic [1:0] T_BODY      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FLITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t                         r_state, w_state_next;
  logic [FLIT_WIDTH-1:0]          r_asm [MAX_FLITS];
  logic [FLIT_WIDTH-1:0]          w_merged [MAX_FLITS];
  logic [MAX_FLITS*FLIT_WIDTH-1:0] w_merged_flat;
  logic [CNT_W-1:0]               r_count, w_count_next, w_fill;
  logic [CNT_W-1:0]               w_store_idx;
  logic                           w_store, w_complete, w_load, w_perr;
  logic                           w_accept, w_out_free;
  logic [1:0]                     w_type;
  logic                           r_out_valid, r_perr;
  logic [MAX_FLITS*FLIT_WIDTH-1:0] r_out_flit;
  logic [CNT_W-1:0]               r_out_count;

  assign received_flit_ready = rst_n & (r_state != S_WAIT_OUT);
  assign w_accept   = received_flit_valid & received_flit_ready;
  assign w_type     = received_flit[FLIT_WIDTH-1 -: 2];
  assign w_out_free = ~r_out_valid | received_packet_consumed;

  always_comb begin
    w_state_next = r_state;
    w_store      = 1'b0;
    w_store_idx  = '0;
    w_fill       = r_count;
    w_complete   = 1'b0;
    w_perr       = 1'b0;
    w_load       = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        S_IDLE, S_DISCARD: begin
          if (w_type == T_HEAD || w_type == T_HEAD_TAIL) begin
            w_store      = 1'b1;
            w_fill       = ONE_CNT;
            w_complete   = (w_type == T_HEAD_TAIL);
            w_state_next = S_ASSEMBLE;
          end else if (r_state == S_IDLE) begin
            w_perr = 1'b1;
          end else if (w_type == T_TAIL) begin
            w_state_next = S_IDLE;
          end
        end
        S_ASSEMBLE: begin
          if (w_type == T_HEAD || w_type == T_HEAD_TAIL) begin
            // A fresh head abandons whatever was being assembled
            w_perr     = 1'b1;
            w_store    = 1'b1;
            w_fill     = ONE_CNT;
            w_complete = (w_type == T_HEAD_TAIL);
          end else if (r_count == MAX_CNT) begin
            w_perr       = 1'b1;
            w_state_next = (w_type == T_BODY) ? S_DISCARD : S_IDLE;
          end else begin
            w_store     = 1'b1;
            w_store_idx = r_count;
            w_fill      = r_count + ONE_CNT;
            w_complete  = (w_type == T_TAIL);
          end
        end
        default: ;
      endcase
    end
    if (w_complete) begin
      if (w_out_free) begin
        w_load       = 1'b1;
        w_state_next = S_IDLE;
      end else begin
        w_state_next = S_WAIT_OUT;
      end
    end
    if (r_state == S_WAIT_OUT && received_packet_consumed) begin
      w_load       = 1'b1;
      w_state_next = S_IDLE;
    end
    w_count_next = w_load ? '0 : w_fill;
  end

  // Output loads see the flit being written this cycle through the merge view
  generate
    for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_slot
      assign w_merged[gi] = (w_store && w_store_idx == CNT_W'(gi)) ? received_flit : r_asm[gi];
      assign w_merged_flat[gi*FLIT_WIDTH +: FLIT_WIDTH] = w_merged[gi];
      always_ff @(posedge nocclk) begin
        r_asm[gi] <= w_merged[gi];
      end
    end
  endgenerate

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_perr      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_perr  <= w_perr;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_flit  <= w_merged_flat;
        r_out_count <= w_fill;
      end else if (received_packet_consumed) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign received_packet_valid      = r_out_valid;
  assign received_packet_flit       = r_out_flit;
  assign received_packet_tail_index = r_out_count;
  assign protocol_error             = r_perr;

endmodule

// File: tb/tb_packet_receive_buffer.sv
// Directed bench for packet_receive_buffer: hand-computed expectations checked
// with immediate assertions, one line per transaction.
module tb_packet_receive_buffer;

  localparam int FW = 64;
  localparam int MF = 8;
  localparam int CW = $clog2(MF + 1);

  logic                 nocclk = 1'b0;
  logic                 rst_n;
  logic                 received_flit_valid;
  logic [FW-1:0]        received_flit;
  logic                 received_flit_ready;
  logic                 received_packet_valid;
  logic [MF*FW-1:0]     received_packet_flit;
  logic [CW-1:0]        received_packet_tail_index;
  logic                 received_packet_consumed;
  logic                 protocol_error;

  int n_checks = 0;
  int n_errors = 0;

  packet_receive_buffer #(.FLIT_WIDTH(FW), .MAX_FLITS(MF)) dut (
    .nocclk                     (nocclk),
    .rst_n                      (rst_n),
    .received_flit_valid        (received_flit_valid),
    .received_flit              (received_flit),
    .received_flit_ready        (received_flit_ready),
    .received_packet_valid      (received_packet_valid),
    .received_packet_flit       (received_packet_flit),
    .received_packet_tail_index (received_packet_tail_index),
    .received_packet_consumed   (received_packet_consumed),
    .protocol_error             (protocol_error)
  );

  always #5 nocclk = ~nocclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic send(input logic [63:0] f);
    received_flit_valid = 1'b1;
    received_flit       = f;
    tick();
    $display("flit %h accepted_edge ready_now=%0b pkt_valid=%0b tail=%0d perr=%0b",
             f, received_flit_ready, received_packet_valid,
             received_packet_tail_index, protocol_error);
  endtask

  task automatic consume(input string tag);
    received_flit_valid      = 1'b0;
    received_packet_consumed = 1'b1;
    tick();
    received_packet_consumed = 1'b0;
    $display("consume %s", tag);
    chk({tag, "_valid_clears"}, 64'(received_packet_valid), 64'd0);
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [61:0] p);
    return {t, p};
  endfunction

  function automatic logic [63:0] pf(input int i);
    return received_packet_flit[i*FW +: FW];
  endfunction

  logic [63:0] h0, b1, b2, t3, ht, a1, c1, bb0, bb1, x0, x1, y0, y1, w0;

  initial begin
    h0 = mk(2'b00, 62'h11); b1 = mk(2'b01, 62'h22);
    b2 = mk(2'b01, 62'h33); t3 = mk(2'b10, 62'h44);
    ht = 64'hC000_0000_0000_00AA;
    a1 = mk(2'b11, 62'hA1); c1 = mk(2'b11, 62'hC1);
    bb0 = mk(2'b00, 62'hB0); bb1 = mk(2'b10, 62'hB1);
    x0 = mk(2'b00, 62'h50); x1 = mk(2'b01, 62'h51);
    y0 = mk(2'b00, 62'h60); y1 = mk(2'b10, 62'h61);
    w0 = mk(2'b11, 62'h77);

    rst_n = 1'b0; received_flit_valid = 1'b0; received_flit = '0;
    received_packet_consumed = 1'b0;
    tick(); tick();
    $display("reset asserted");
    chk("rst_ready", 64'(received_flit_ready), 64'd0);
    chk("rst_valid", 64'(received_packet_valid), 64'd0);
    chk("rst_tail", 64'(received_packet_tail_index), 64'd0);
    chk("rst_perr", 64'(protocol_error), 64'd0);
    chk("rst_flit0", pf(0), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(received_flit_ready), 64'd1);

    // Four-flit packet streamed back to back
    send(h0); chk("p4_ready1", 64'(received_flit_ready), 64'd1);
    send(b1); chk("p4_ready2", 64'(received_flit_ready), 64'd1);
    send(b2); chk("p4_novalid", 64'(received_packet_valid), 64'd0);
    send(t3);
    chk("p4_valid", 64'(received_packet_valid), 64'd1);
    chk("p4_tail", 64'(received_packet_tail_index), 64'd4);
    chk("p4_f0", pf(0), h0); chk("p4_f1", pf(1), b1);
    chk("p4_f2", pf(2), b2); chk("p4_f3", pf(3), t3);
    chk("p4_perr", 64'(protocol_error), 64'd0);
    consume("p4");

    // Single-flit packet, then a second one completing as the first is consumed
    send(ht);
    chk("ht_valid", 64'(received_packet_valid), 64'd1);
    chk("ht_tail", 64'(received_packet_tail_index), 64'd1);
    chk("ht_f0", pf(0), ht);
    chk("ht_perr", 64'(protocol_error), 64'd0);
    received_packet_consumed = 1'b1;
    send(c1);
    received_packet_consumed = 1'b0;
    chk("sim_valid", 64'(received_packet_valid), 64'd1);
    chk("sim_f0", pf(0), c1);
    chk("sim_ready", 64'(received_flit_ready), 64'd1);
    consume("sim");

    // Second packet completes while the first is still held
    send(a1); chk("wo_a_valid", 64'(received_packet_valid), 64'd1);
    send(bb0);
    send(bb1);
    received_flit_valid = 1'b0;
    chk("wo_ready0", 64'(received_flit_ready), 64'd0);
    chk("wo_holdA", pf(0), a1);
    chk("wo_holdA_tail", 64'(received_packet_tail_index), 64'd1);
    tick();
    chk("wo_ready_still0", 64'(received_flit_ready), 64'd0);
    received_packet_consumed = 1'b1;
    tick();
    received_packet_consumed = 1'b0;
    $display("consume wait_out");
    chk("wo_valid", 64'(received_packet_valid), 64'd1);
    chk("wo_tail", 64'(received_packet_tail_index), 64'd2);
    chk("wo_f0", pf(0), bb0); chk("wo_f1", pf(1), bb1);
    chk("wo_ready1", 64'(received_flit_ready), 64'd1);
    consume("wo");

    // Overflow: HEAD + 8 BODY, the last body is the ninth flit
    send(mk(2'b00, 62'h900));
    for (int i = 1; i <= 7; i++) send(mk(2'b01, 62'(32'h900 + i)));
    chk("ov_perr_before", 64'(protocol_error), 64'd0);
    send(mk(2'b01, 62'h908));
    chk("ov_perr", 64'(protocol_error), 64'd1);
    send(mk(2'b10, 62'h909));
    chk("ov_perr_once", 64'(protocol_error), 64'd0);
    chk("ov_nopkt", 64'(received_packet_valid), 64'd0);
    send(ht);
    received_flit_valid = 1'b0;
    chk("ov_next_valid", 64'(received_packet_valid), 64'd1);
    chk("ov_next_tail", 64'(received_packet_tail_index), 64'd1);
    chk("ov_next_f0", pf(0), ht);
    chk("ov_next_perr", 64'(protocol_error), 64'd0);
    consume("ov");

    // Stray BODY in IDLE, then a HEAD that abandons a partial packet
    send(mk(2'b01, 62'h5));
    chk("idle_body_perr", 64'(protocol_error), 64'd1);
    chk("idle_body_nopkt", 64'(received_packet_valid), 64'd0);
    send(x0); chk("ab_perr_clear", 64'(protocol_error), 64'd0);
    send(x1);
    send(y0); chk("ab_perr", 64'(protocol_error), 64'd1);
    send(y1);
    received_flit_valid = 1'b0;
    chk("ab_perr_once", 64'(protocol_error), 64'd0);
    chk("ab_valid", 64'(received_packet_valid), 64'd1);
    chk("ab_tail", 64'(received_packet_tail_index), 64'd2);
    chk("ab_f0", pf(0), y0); chk("ab_f1", pf(1), y1);
    consume("ab");

    // Reset with a pending packet and a partial one
    send(ht);
    send(x0);
    send(x1);
    received_flit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    $display("reset mid-packet");
    chk("mr_valid", 64'(received_packet_valid), 64'd0);
    chk("mr_tail", 64'(received_packet_tail_index), 64'd0);
    chk("mr_ready", 64'(received_flit_ready), 64'd0);
    chk("mr_perr", 64'(protocol_error), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_ready_rel", 64'(received_flit_ready), 64'd1);
    send(w0);
    received_flit_valid = 1'b0;
    chk("mr_new_valid", 64'(received_packet_valid), 64'd1);
    chk("mr_new_tail", 64'(received_packet_tail_index), 64'd1);
    chk("mr_new_f0", pf(0), w0);
    chk("mr_new_perr", 64'(protocol_error), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
